avst_packet_arbiter: RTL

- Packet-atomic round-robin arbiter sharing the 64-bit Avalon-ST input of the width converter between N_SRC upstream sources.
- Grants one source per packet and holds the grant from the first accepted beat to the eop beat.
- Forwards the source's data, empty and channel through a one-beat registered stage into the converter sink port.
- Same sop/eop/empty/channel semantics as the converter interface.

---
 rtl/avst_packet_arbiter_if.sv | 83 ++++++++
 rtl/avst_packet_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/avst_packet_arbiter_if.sv
// ---------------------------------------------------------------------------
// avst_packet_arbiter_if
//
// Bundles the signals around avst_packet_arbiter: N_SRC upstream Avalon-ST
// sources on one side and the single 64-bit converter sink port on the other.
//
//   src_data_i          N_SRC*DATA_IN_W   source k at [k*DATA_IN_W +: DATA_IN_W]
//   src_empty_i         N_SRC*EMPTY_IN_W  per-source empty (meaningful on eop)
//   src_channel_i       N_SRC*CHANNEL_W   per-source channel
//   src_startofpacket_i N_SRC             per-source sop
//   src_endofpacket_i   N_SRC             per-source eop
//   src_valid_i         N_SRC             per-source valid, doubles as request
//   src_ready_o         N_SRC             per-source ready, at most one bit set
//   ast_data_o          DATA_IN_W         beat to converter
//   ast_empty_o         EMPTY_IN_W        empty to converter
//   ast_channel_o       CHANNEL_W         channel to converter
//   ast_startofpacket_o 1                 sop to converter
//   ast_endofpacket_o   1                 eop to converter
//   ast_valid_o         1                 valid to converter
//   ast_ready_i         1                 ready from converter
//
// Modports:
//   slave  - the arbiter's view (sources and converter ready are inputs)
//   master - the environment's view (sources and converter side)
// ---------------------------------------------------------------------------
interface avst_packet_arbiter_if #(
  parameter int N_SRC      = 4,
  parameter int DATA_IN_W  = 64,
  parameter int CHANNEL_W  = 10,
  parameter int EMPTY_IN_W = ($clog2(DATA_IN_W / 8) < 1) ? 1 : $clog2(DATA_IN_W / 8)
);

  logic [N_SRC*DATA_IN_W-1:0]  src_data_i;
  logic [N_SRC*EMPTY_IN_W-1:0] src_empty_i;
  logic [N_SRC*CHANNEL_W-1:0]  src_channel_i;
  logic [N_SRC-1:0]            src_startofpacket_i;
  logic [N_SRC-1:0]            src_endofpacket_i;
  logic [N_SRC-1:0]            src_valid_i;
  logic [N_SRC-1:0]            src_ready_o;

  logic [DATA_IN_W-1:0]        ast_data_o;
  logic [EMPTY_IN_W-1:0]       ast_empty_o;
  logic [CHANNEL_W-1:0]        ast_channel_o;
  logic                        ast_startofpacket_o;
  logic                        ast_endofpacket_o;
  logic                        ast_valid_o;
  logic                        ast_ready_i;

  modport slave (
    input  src_data_i,
    input  src_empty_i,
    input  src_channel_i,
    input  src_startofpacket_i,
    input  src_endofpacket_i,
    input  src_valid_i,
    output src_ready_o,
    output ast_data_o,
    output ast_empty_o,
    output ast_channel_o,
    output ast_startofpacket_o,
    output ast_endofpacket_o,
    output ast_valid_o,
    input  ast_ready_i
  );

  modport master (
    output src_data_i,
    output src_empty_i,
    output src_channel_i,
    output src_startofpacket_i,
    output src_endofpacket_i,
    output src_valid_i,
    input  src_ready_o,
    input  ast_data_o,
    input  ast_empty_o,
    input  ast_channel_o,
    input  ast_startofpacket_o,
    input  ast_endofpacket_o,
    input  ast_valid_o,
    output ast_ready_i
  );

endinterface

// File: rtl/avst_packet_arbiter.sv
// ---------------------------------------------------------------------------
// avst_packet_arbiter
//
// Packet-atomic round-robin arbiter in front of the 64-bit Avalon-ST input of
// the width converter. One source is granted per packet; the grant is held
// from the first accepted beat until the eop beat is accepted. Beats pass
// through a single registered stage (1 beat/cycle, 1 cycle latency).
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset (synchronous release expected)
//   bus          avst_packet_arbiter_if.slave: sources in, converter port out
//   grant_idx_o  currently / most recently granted source index
//   busy_o       high while a packet is locked to the granted source
//
// Arbitration: in IDLE the first requesting source at or after the round-robin
// pointer (wrapping at N_SRC-1) is granted on the next edge. After the eop
// beat the pointer moves to grant+1, so every other requester is served
// before the same source wins again.
// ---------------------------------------------------------------------------
module avst_packet_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_IN_W  = 64,
  parameter int CHANNEL_W  = 10,
  parameter int EMPTY_IN_W = ($clog2(DATA_IN_W / 8) < 1) ? 1 : $clog2(DATA_IN_W / 8),
  parameter int SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  avst_packet_arbiter_if.slave bus,
  output logic [SRC_W-1:0]     grant_idx_o,
  output logic                 busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Control state
  state_t                state_q;
  logic [SRC_W-1:0]      ptr_q;
  logic [SRC_W-1:0]      grant_q;
  logic                  busy_q;

  // Output register stage
  logic                  out_valid_q;
  logic [DATA_IN_W-1:0]  data_q;
  logic [EMPTY_IN_W-1:0] empty_q;
  logic [CHANNEL_W-1:0]  channel_q;
  logic                  sop_q;
  logic                  eop_q;

  // Combinational next-state / selection
  logic [SRC_W-1:0]      pick_d;
  logic                  found_d;
  logic                  any_req_d;
  logic [SRC_W-1:0]      ptr_d;
  logic [N_SRC-1:0]      ready_d;
  logic                  can_load_d;
  logic                  accept_d;

  logic [DATA_IN_W-1:0]  sel_data_d;
  logic [EMPTY_IN_W-1:0] sel_empty_d;
  logic [CHANNEL_W-1:0]  sel_channel_d;
  logic                  sel_sop_d;
  logic                  sel_eop_d;
  logic                  sel_valid_d;

  // ------------------------------------------------------------------
  // Round-robin search. The first loop covers indices ptr..N_SRC-1, the
  // second covers 0..N_SRC-1 again so that indices below ptr are reached
  // after the wrap; the found flag keeps the earliest hit.
  // ------------------------------------------------------------------
  always_comb begin
    pick_d    = ptr_q;
    found_d   = 1'b0;
    any_req_d = |bus.src_valid_i;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found_d && bus.src_valid_i[k] && (SRC_W'(k) >= ptr_q)) begin
        pick_d  = SRC_W'(k);
        found_d = 1'b1;
      end
    end
    for (int k = 0; k < N_SRC; k++) begin
      if (!found_d && bus.src_valid_i[k]) begin
        pick_d  = SRC_W'(k);
        found_d = 1'b1;
      end
    end
  end

  // Pointer after the granted packet completes; explicit wrap so that a
  // non power-of-two N_SRC never produces an out-of-range index.
  always_comb begin
    if (grant_q == SRC_W'(N_SRC - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_q + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Granted-source mux and ready generation. The stage can take a beat when
  // it is empty or is being drained this cycle.
  // ------------------------------------------------------------------
  always_comb begin
    sel_data_d    = '0;
    sel_empty_d   = '0;
    sel_channel_d = '0;
    sel_sop_d     = 1'b0;
    sel_eop_d     = 1'b0;
    sel_valid_d   = 1'b0;
    ready_d       = '0;
    can_load_d    = !out_valid_q || bus.ast_ready_i;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == SRC_W'(k)) begin
        sel_data_d    = bus.src_data_i[k*DATA_IN_W +: DATA_IN_W];
        sel_empty_d   = bus.src_empty_i[k*EMPTY_IN_W +: EMPTY_IN_W];
        sel_channel_d = bus.src_channel_i[k*CHANNEL_W +: CHANNEL_W];
        sel_sop_d     = bus.src_startofpacket_i[k];
        sel_eop_d     = bus.src_endofpacket_i[k];
        sel_valid_d   = bus.src_valid_i[k];
        ready_d[k]    = (state_q == BUSY) && can_load_d;
      end
    end
    accept_d = (state_q == BUSY) && sel_valid_d && can_load_d;
  end

  // ------------------------------------------------------------------
  // Arbitration FSM. grant_q keeps its value in IDLE so grant_idx_o shows
  // the last granted source between packets.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q <= BUSY;
            grant_q <= pick_d;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (accept_d && sel_eop_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output register stage. A load takes priority over a drain so that a
  // simultaneous drain+load keeps valid high with the new beat. Fields are
  // left untouched on a plain drain; they are only meaningful with valid.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      empty_q     <= '0;
      channel_q   <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else if (accept_d) begin
      out_valid_q <= 1'b1;
      data_q      <= sel_data_d;
      empty_q     <= sel_empty_d;
      channel_q   <= sel_channel_d;
      sop_q       <= sel_sop_d;
      eop_q       <= sel_eop_d;
    end else if (out_valid_q && bus.ast_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.src_ready_o         = ready_d;
  assign bus.ast_data_o          = data_q;
  assign bus.ast_empty_o         = empty_q;
  assign bus.ast_channel_o       = channel_q;
  assign bus.ast_startofpacket_o = sop_q;
  assign bus.ast_endofpacket_o   = eop_q;
  assign bus.ast_valid_o         = out_valid_q;
  assign grant_idx_o             = grant_q;
  assign busy_o                  = busy_q;

endmodule
